// File: rtl/com_host_sequencer.sv
// com_host_sequencer: host-side initiator for the multi-core com port.
// Packs received bytes into 16-bit words and writes them to DRAM, releases
// the cores, waits for end_process, then reads a result window back and
// streams it out as bytes (high byte first).
// Optional feature macro: CHECKSUM_EN -- appends an XOR checksum byte to the
// readback stream and exposes the XOR of loaded bytes on load_csum.
module com_host_sequencer #(
    parameter logic [15:0] LOAD_WORDS = 16'd256,
    parameter logic [15:0] READ_BASE  = 16'd0,
    parameter logic [15:0] READ_WORDS = 16'd256,
    parameter int          RD_LAT     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [1:0]  status,
    output logic [15:0] com_addr,
    output logic [15:0] com_data_in,
    output logic        com_wr_en,
    input  logic [15:0] com_data_out,
    input  logic        end_process,
    output logic        busy,
    output logic        done
`ifdef CHECKSUM_EN
    ,
    output logic [7:0]  load_csum
`endif
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_READ = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Readback sub-phases: wait for read latency, send high, send low
    localparam logic [1:0] RP_WAIT = 2'd0;
    localparam logic [1:0] RP_HI   = 2'd1;
    localparam logic [1:0] RP_LO   = 2'd2;
`ifdef CHECKSUM_EN
    localparam logic [1:0] RP_CSUM = 2'd3;
`endif

    localparam logic [7:0]  LAT_LAST  = 8'(RD_LAT);
    localparam logic [15:0] LOAD_LAST = LOAD_WORDS - 16'd1;
    localparam logic [15:0] READ_LAST = READ_WORDS - 16'd1;

    logic [2:0]  state_q,       state_d;
    logic        byte_lo_q,     byte_lo_d;     // next load byte is the low byte
    logic [7:0]  hi_q,          hi_d;
    logic [15:0] word_q,        word_d;
    logic [15:0] com_addr_q,    com_addr_d;
    logic [15:0] com_data_in_q, com_data_in_d;
    logic        com_wr_en_q,   com_wr_en_d;
    logic [7:0]  tx_data_q,     tx_data_d;
    logic        tx_valid_q,    tx_valid_d;
    logic [1:0]  rd_phase_q,    rd_phase_d;
    logic [7:0]  lat_q,         lat_d;
    logic [15:0] rd_idx_q,      rd_idx_d;
    logic [7:0]  lo_q,          lo_d;          // low byte of the latched word
`ifdef CHECKSUM_EN
    logic [7:0]  tx_csum_q,     tx_csum_d;
    logic [7:0]  load_csum_q,   load_csum_d;
`endif

    // Next-state and datapath logic for all phases
    always_comb begin
        state_d       = state_q;
        byte_lo_d     = byte_lo_q;
        hi_d          = hi_q;
        word_d        = word_q;
        com_addr_d    = com_addr_q;
        com_data_in_d = com_data_in_q;
        com_wr_en_d   = 1'b0;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        rd_phase_d    = rd_phase_q;
        lat_d         = lat_q;
        rd_idx_d      = rd_idx_q;
        lo_d          = lo_q;
`ifdef CHECKSUM_EN
        tx_csum_d     = tx_csum_q;
        load_csum_d   = load_csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // The byte that wakes us up is the high byte of word 0
                if (rx_valid) begin
                    state_d   = ST_LOAD;
                    hi_d      = rx_data;
                    byte_lo_d = 1'b1;
`ifdef CHECKSUM_EN
                    load_csum_d = load_csum_q ^ rx_data;
`endif
                end
            end
            ST_LOAD: begin
                if (com_wr_en_q && (com_addr_q == LOAD_LAST)) begin
                    // Last write has just been issued; leave LOAD after it
                    state_d = ST_RUN;
                end else if (rx_valid) begin
`ifdef CHECKSUM_EN
                    load_csum_d = load_csum_q ^ rx_data;
`endif
                    if (!byte_lo_q) begin
                        hi_d      = rx_data;
                        byte_lo_d = 1'b1;
                    end else begin
                        com_data_in_d = {hi_q, rx_data};
                        com_addr_d    = word_q;
                        com_wr_en_d   = 1'b1;
                        word_d        = word_q + 16'd1;
                        byte_lo_d     = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (end_process) begin
                    state_d    = ST_READ;
                    com_addr_d = READ_BASE;
                    lat_d      = 8'd0;
                    rd_idx_d   = 16'd0;
                    rd_phase_d = RP_WAIT;
                end
            end
            ST_READ: begin
                case (rd_phase_q)
                    RP_WAIT: begin
                        if (lat_q == LAT_LAST) begin
                            tx_data_d  = com_data_out[15:8];
                            lo_d       = com_data_out[7:0];
                            tx_valid_d = 1'b1;
                            rd_phase_d = RP_HI;
                        end else begin
                            lat_d = lat_q + 8'd1;
                        end
                    end
                    RP_HI: begin
                        if (tx_ready) begin
                            tx_data_d  = lo_q;
                            rd_phase_d = RP_LO;
`ifdef CHECKSUM_EN
                            tx_csum_d  = tx_csum_q ^ tx_data_q;
`endif
                        end
                    end
                    RP_LO: begin
                        if (tx_ready) begin
`ifdef CHECKSUM_EN
                            tx_csum_d = tx_csum_q ^ tx_data_q;
`endif
                            if (rd_idx_q == READ_LAST) begin
`ifdef CHECKSUM_EN
                                tx_data_d  = tx_csum_q ^ tx_data_q;
                                rd_phase_d = RP_CSUM;
`else
                                tx_valid_d = 1'b0;
                                state_d    = ST_DONE;
`endif
                            end else begin
                                tx_valid_d = 1'b0;
                                rd_idx_d   = rd_idx_q + 16'd1;
                                com_addr_d = com_addr_q + 16'd1;
                                lat_d      = 8'd0;
                                rd_phase_d = RP_WAIT;
                            end
                        end
                    end
                    default: begin
`ifdef CHECKSUM_EN
                        if (rd_phase_q == RP_CSUM && tx_ready) begin
                            tx_valid_d = 1'b0;
                            state_d    = ST_DONE;
                        end
`endif
                    end
                endcase
            end
            default: begin
                // DONE (and any unused encoding) holds until reset
            end
        endcase
    end

    // State registers with asynchronous reset to idle values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            byte_lo_q     <= 1'b0;
            hi_q          <= 8'd0;
            word_q        <= 16'd0;
            com_addr_q    <= 16'd0;
            com_data_in_q <= 16'd0;
            com_wr_en_q   <= 1'b0;
            tx_data_q     <= 8'd0;
            tx_valid_q    <= 1'b0;
            rd_phase_q    <= RP_WAIT;
            lat_q         <= 8'd0;
            rd_idx_q      <= 16'd0;
            lo_q          <= 8'd0;
`ifdef CHECKSUM_EN
            tx_csum_q     <= 8'd0;
            load_csum_q   <= 8'd0;
`endif
        end else begin
            state_q       <= state_d;
            byte_lo_q     <= byte_lo_d;
            hi_q          <= hi_d;
            word_q        <= word_d;
            com_addr_q    <= com_addr_d;
            com_data_in_q <= com_data_in_d;
            com_wr_en_q   <= com_wr_en_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            rd_phase_q    <= rd_phase_d;
            lat_q         <= lat_d;
            rd_idx_q      <= rd_idx_d;
            lo_q          <= lo_d;
`ifdef CHECKSUM_EN
            tx_csum_q     <= tx_csum_d;
            load_csum_q   <= load_csum_d;
`endif
        end
    end

    // Mode and handshake outputs decoded from the current state
    always_comb begin
        status = 2'd0;
        busy   = 1'b0;
        done   = 1'b0;
        case (state_q)
            ST_LOAD: begin status = 2'd1; busy = 1'b1; end
            ST_RUN:  begin status = 2'd2; busy = 1'b1; end
            ST_READ: begin status = 2'd3; busy = 1'b1; end
            ST_DONE: begin done = 1'b1; end
            default: begin end
        endcase
    end

    assign com_addr    = com_addr_q;
    assign com_data_in = com_data_in_q;
    assign com_wr_en   = com_wr_en_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
`ifdef CHECKSUM_EN
    assign load_csum   = load_csum_q;
`endif

endmodule

// File: tb/tb_com_host_sequencer.sv
// Testbench for com_host_sequencer: load two words, run, read back across
// the 16'hFFFF wrap with transmitter back-pressure, reset abort mid-load.
module tb_com_host_sequencer;

    localparam logic [15:0] LW = 16'd2;
    localparam logic [15:0] RB = 16'hFFFF;
    localparam logic [15:0] RW = 16'd2;
    localparam int          RL = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [1:0]  status;
    logic [15:0] com_addr;
    logic [15:0] com_data_in;
    logic        com_wr_en;
    logic [15:0] com_data_out;
    logic        end_process;
    logic        busy;
    logic        done;
`ifdef CHECKSUM_EN
    logic [7:0]  load_csum;
`endif

    com_host_sequencer #(
        .LOAD_WORDS (LW),
        .READ_BASE  (RB),
        .READ_WORDS (RW),
        .RD_LAT     (RL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .status       (status),
        .com_addr     (com_addr),
        .com_data_in  (com_data_in),
        .com_wr_en    (com_wr_en),
        .com_data_out (com_data_out),
        .end_process  (end_process),
        .busy         (busy),
        .done         (done)
`ifdef CHECKSUM_EN
        ,
        .load_csum    (load_csum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] exp_addr;
        logic [15:0] exp_data;
    } load_vec_t;

    typedef struct {
        logic [15:0] exp_addr;
        logic [7:0]  exp_hi;
        logic [7:0]  exp_lo;
    } read_vec_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    load_vec_t load_tab [2];
    read_vec_t read_tab [2];
    wr_t       wr_q [$];
    logic [7:0] tx_q [$];

    int checks = 0;
    int errors = 0;
    logic prev_wr = 1'b0;

    // DRAM model: address pipelined RL cycles, then a combinational lookup
    logic [15:0] a0, a1;
    always @(posedge clk) begin
        a0 <= com_addr;
        a1 <= a0;
    end

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        case (a)
            16'hFFFF: mem_f = 16'h5A01;
            16'h0000: mem_f = 16'h0203;
            default:  mem_f = 16'hDEAD;
        endcase
    endfunction

    assign com_data_out = mem_f(a1);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_status"},   32'(status), 32'd0);
        check({tag, "_addr"},     32'(com_addr), 32'd0);
        check({tag, "_data_in"},  32'(com_data_in), 32'd0);
        check({tag, "_wr_en"},    32'(com_wr_en), 32'd0);
        check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        check({tag, "_tx_data"},  32'(tx_data), 32'd0);
        check({tag, "_busy"},     32'(busy), 32'd0);
        check({tag, "_done"},     32'(done), 32'd0);
`ifdef CHECKSUM_EN
        check({tag, "_load_csum"}, 32'(load_csum), 32'd0);
`endif
    endtask

    // Scoreboard monitor: pops expected writes and tx bytes as they appear
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (com_wr_en) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 32'(com_addr), 32'hFFFFFFFF);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    check("wr_addr", 32'(com_addr), 32'(w.addr));
                    check("wr_data", 32'(com_data_in), 32'(w.data));
                    $display("write addr=%h data=%h", com_addr, com_data_in);
                end
                check("wr_in_load", 32'(status), 32'd1);
                check("wr_one_cycle", 32'(prev_wr), 32'd0);
                check("wr_tx_exclusive", 32'(tx_valid), 32'd0);
            end
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) begin
                    check("unexpected_tx", 32'(tx_data), 32'hFFFFFFFF);
                end else begin
                    logic [7:0] b;
                    b = tx_q.pop_front();
                    check("tx_byte", 32'(tx_data), 32'(b));
                    $display("tx byte=%h", tx_data);
                end
            end
            prev_wr = com_wr_en;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
    endtask

    task automatic summary;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
    endtask

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        errors++;
        summary();
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nbytes;
        load_tab[0] = '{hi: 8'h12, lo: 8'h34, exp_addr: 16'h0000, exp_data: 16'h1234};
        load_tab[1] = '{hi: 8'hAB, lo: 8'hCD, exp_addr: 16'h0001, exp_data: 16'hABCD};
        read_tab[0] = '{exp_addr: 16'hFFFF, exp_hi: 8'h5A, exp_lo: 8'h01};
        read_tab[1] = '{exp_addr: 16'h0000, exp_hi: 8'h02, exp_lo: 8'h03};

        rst_n = 1'b0;
        rx_data = 8'd0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        end_process = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;

        // Reset mid-load discards the partial word
        send_byte(8'h77);
        @(posedge clk);
        #1 rx_valid = 1'b0;
        @(negedge clk);
        check("abort_pre_status", 32'(status), 32'd1);
        check("abort_pre_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset("abort");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Load phase, bytes back-to-back (a byte coincides with each write)
        for (int i = 0; i < 2; i++) begin
            wr_q.push_back('{addr: load_tab[i].exp_addr, data: load_tab[i].exp_data});
        end
        for (int i = 0; i < 2; i++) begin
            send_byte(load_tab[i].hi);
            send_byte(load_tab[i].lo);
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
        @(negedge clk);
        check("last_wr_en", 32'(com_wr_en), 32'd1);
        check("last_wr_status", 32'(status), 32'd1);
        @(negedge clk);
        check("run_status", 32'(status), 32'd2);
        check("run_wr_en", 32'(com_wr_en), 32'd0);
        check("wr_queue_empty", 32'(wr_q.size()), 32'd0);
`ifdef CHECKSUM_EN
        check("load_csum", 32'(load_csum), 32'h40);
`endif

        // RUN: a stray byte is dropped, 50 cycles with no activity
        send_byte(8'hEE);
        @(posedge clk);
        #1 rx_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("run_idle", {29'd0, status, com_wr_en | tx_valid}, {29'd0, 2'd2, 1'b0});
        end
        @(posedge clk);
        #1 end_process = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("read_status", 32'(status), 32'd3);

        // Readback with back-pressure on the second byte
        for (int i = 0; i < 2; i++) begin
            tx_q.push_back(read_tab[i].exp_hi);
            tx_q.push_back(read_tab[i].exp_lo);
        end
`ifdef CHECKSUM_EN
        tx_q.push_back(read_tab[0].exp_hi ^ read_tab[0].exp_lo ^
                       read_tab[1].exp_hi ^ read_tab[1].exp_lo);
        nbytes = 5;
`else
        nbytes = 4;
`endif
        for (int b = 0; b < nbytes; b++) begin
            n = 0;
            while (!tx_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("tx_valid_wait", 32'(tx_valid), 32'd1);
            if (b < 4 && (b % 2) == 0) begin
                check("read_addr", 32'(com_addr), 32'(read_tab[b / 2].exp_addr));
            end
            if (b == 1) begin
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    check("hold_stable", {7'd0, tx_valid, tx_data, com_addr},
                          {7'd0, 1'b1, read_tab[0].exp_lo, read_tab[0].exp_addr});
                end
            end
            @(posedge clk);
            #1 tx_ready = 1'b1;
            @(posedge clk);
            #1 tx_ready = 1'b0;
            @(negedge clk);
        end
        check("done", 32'(done), 32'd1);
        check("done_status", 32'(status), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        check("done_tx_valid", 32'(tx_valid), 32'd0);
        check("tx_queue_empty", 32'(tx_q.size()), 32'd0);

        // DONE ignores rx and persists
        send_byte(8'h55);
        @(posedge clk);
        #1 rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("done_hold", {30'd0, done, com_wr_en}, {30'd0, 1'b1, 1'b0});

        summary();
        $finish;
    end

endmodule

// File: doc/com_host_sequencer.md
Name: com_host_sequencer

Overview:
- Host-side initiator for the multi-core top's external com port: a byte stream (from a UART receiver) is packed into 16-bit words and written into data memory over com_addr/com_data_in/com_wr_en.
- Then drives status to release the cores, waits for end_process, and reads a result window back over com_data_out.
- Result words are streamed out as bytes toward a UART transmitter.
- Sits between the serial front end and the top-level processor/selector/DRAM complex.

Parameters:
- LOAD_WORDS, 16'd256, number of 16-bit words written during the load phase (must be ≥1).
- READ_BASE, 16'd0, first DRAM address read back.
- READ_WORDS, 16'd256, number of words read back (must be ≥1).
- RD_LAT, 2, cycles from com_addr change to valid com_data_out.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid, held until accepted
- tx_ready  in  1  transmitter accepts when tx_valid & tx_ready
- status  out  2  processor/selector mode: 0 idle, 1 load, 2 run, 3 readback
- com_addr  out  16  DRAM address via selector
- com_data_in  out  16  write data to DRAM
- com_wr_en  out  1  one-cycle write strobe
- com_data_out  in  16  read data from DRAM
- end_process  in  1  cores finished (level)
- busy  out  1  high in LOAD, RUN, READ
- done  out  1  high in DONE

Behaviour:
- Reset (async, rst_n=0): state IDLE; status=0, com_addr=0, com_data_in=0, com_wr_en=0, tx_valid=0, tx_data=0, busy=0, done=0; byte/word counters cleared.
- IDLE: first rx_valid → LOAD (that byte counts as the first byte); status=1 from the next cycle.
- LOAD:
  - Bytes pair big-endian: first byte is the high byte.
  - On the low byte's rx_valid, the next cycle drives com_data_in={hi,lo}, com_addr=word index (0..LOAD_WORDS-1), com_wr_en=1 for exactly one cycle.
  - Word index increments after each write.
  - After write LOAD_WORDS-1 → RUN.
  - A rx_valid arriving in the same cycle as com_wr_en is accepted normally (no byte lost).
- RUN:
  - status=2; com_wr_en=0; rx_valid ignored (dropped).
  - end_process sampled high → READ.
  - If end_process is already high on entry, go to READ after one cycle in RUN.
- READ:
  - status=3; for each k in 0..READ_WORDS-1, com_addr=READ_BASE+k (16-bit wrap at 16'hFFFF→0).
  - Wait RD_LAT cycles, latch com_data_out.
  - Present the high byte then the low byte on tx_data with tx_valid.
  - tx_data is held stable while tx_valid & !tx_ready.
  - The next address is issued only after the low byte is accepted.
  - After the last word's low byte is accepted → DONE.
- DONE: status=0, done=1, busy=0; rx ignored; remains until reset.
- rst_n low mid-phase aborts immediately to the reset values.
  - A partial word in LOAD is discarded.
  - No com_wr_en glitch on reset release.
- Only one of {com_wr_en, tx_valid} is ever active per state; com_wr_en never asserts outside LOAD.

Optional Feature:
- CHECKSUM_EN defined:
  - After the last readback byte, one extra byte is sent: the XOR of all READ_WORDS*2 transmitted bytes.
  - The load phase also accumulates the XOR of received bytes, exposed on an extra output load_csum[7:0] (reset 0).
  - DONE is entered after the checksum byte is accepted.
- Not defined: no extra byte, no load_csum port, DONE follows the last data byte.

Test Plan:
- LOAD_WORDS=2: bytes 12,34,AB,CD → writes (addr0,16'h1234) then (addr1,16'hABCD), each com_wr_en exactly 1 cycle; status 1→2 after second write.
- RUN: hold end_process=0 for 50 cycles → status stays 2, no com or tx activity; raise end_process → status=3 next cycle.
- READ_BASE=16'hFFFF, READ_WORDS=2, memory returns 16'h5A01, 16'h0203 → com_addr FFFF then 0000; tx bytes 5A,01,02,03 in order.
- tx_ready held low 10 cycles on the second byte → tx_data=01 stable, tx_valid high throughout, no address advance.
- rst_n pulsed low after a single load byte → all outputs at reset values at once; the next 2 bytes are written to addr 0.
- CHECKSUM_EN with the bytes above → extra tx byte 5A^01^02^03=16'h5A (8'h5A), then done=1.
